// File: rtl/cfg_chain_loader.sv
// Streams host config words MSB-first into a tile scan chain.
// Ports: start/abort control; in_valid/in_ready/in_data host words;
//   cfg_en/cfg_dout chain head; busy/done/err status.
module cfg_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 48,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              cfg_en,
  output logic              cfg_dout,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BLW = $clog2(WORD_W + 1);
  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int ICW = $clog2(TIMEOUT + 1);

  localparam logic [BLW-1:0] BL_ONE  = BLW'(1);
  localparam logic [BLW-1:0] BL_FULL = BLW'(WORD_W);
  localparam logic [BCW-1:0] BC_ONE  = BCW'(1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(CHAIN_LEN - 1);
  localparam logic [ICW-1:0] IC_ONE  = ICW'(1);
  localparam logic [ICW-1:0] IC_LAST = ICW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic [BLW-1:0]    bits_left, bits_left_n;
  logic [BCW-1:0]    bit_cnt, bit_cnt_n;
  logic [ICW-1:0]    idle_cnt, idle_cnt_n;
  logic              done_n, err_n;
  logic              accept;

  assign busy     = (state == LOAD);
  assign cfg_en   = busy && (bits_left != '0);
  assign cfg_dout = cfg_en && shreg[WORD_W-1];

  // Accept on the last bit of a word too, so words stream
  // without a bubble, unless that bit completes the chain.
  assign in_ready = busy &&
    ((bits_left == '0) ||
     (bits_left == BL_ONE && bit_cnt < BC_LAST));

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      shreg     <= '0;
      bits_left <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bits_left <= bits_left_n;
      bit_cnt   <= bit_cnt_n;
      idle_cnt  <= idle_cnt_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bits_left_n = bits_left;
    bit_cnt_n   = bit_cnt;
    idle_cnt_n  = idle_cnt;
    done_n      = done;
    err_n       = err;
    if (abort) begin
      state_n     = IDLE;
      bits_left_n = '0;
      idle_cnt_n  = '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state_n     = LOAD;
            bits_left_n = '0;
            bit_cnt_n   = '0;
            idle_cnt_n  = '0;
            done_n      = 1'b0;
            err_n       = 1'b0;
          end
        end
        LOAD: begin
          if (cfg_en) begin
            shreg_n     = shreg << 1;
            bits_left_n = bits_left - BL_ONE;
            bit_cnt_n   = bit_cnt + BC_ONE;
          end
          if (accept) begin
            shreg_n     = in_data;
            bits_left_n = BL_FULL;
          end
          if (cfg_en || accept) begin
            idle_cnt_n = '0;
          end else begin
            idle_cnt_n = idle_cnt + IC_ONE;
          end
          // Completion drops any unshifted tail of the last word.
          if (cfg_en && bit_cnt == BC_LAST) begin
            state_n     = DONE;
            done_n      = 1'b1;
            bits_left_n = '0;
          end else if (!cfg_en && !accept &&
                       idle_cnt == IC_LAST) begin
            state_n    = IDLE;
            err_n      = 1'b1;
            idle_cnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: 48-bit and 20-bit chain instances,
// directed and random loads checked against a bit-stream model.
module tb_cfg_chain_loader;

  logic       clk;
  logic       nrst;
  logic [1:0] start;
  logic [1:0] abort;
  logic [1:0] in_valid;
  logic [7:0] in_data [2];
  wire  [1:0] in_ready;
  wire  [1:0] cfg_en;
  wire  [1:0] cfg_dout;
  wire  [1:0] busy;
  wire  [1:0] done;
  wire  [1:0] err;

  int checks = 0;
  int errors = 0;

  logic [7:0] wq[$];
  int         gq[$];

  cfg_chain_loader #(
    .WORD_W(8), .CHAIN_LEN(48), .TIMEOUT(16)
  ) dut_a (
    .clk(clk), .nrst(nrst),
    .start(start[0]), .abort(abort[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]),
    .cfg_en(cfg_en[0]), .cfg_dout(cfg_dout[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  cfg_chain_loader #(
    .WORD_W(8), .CHAIN_LEN(20), .TIMEOUT(16)
  ) dut_b (
    .clk(clk), .nrst(nrst),
    .start(start[1]), .abort(abort[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]),
    .cfg_en(cfg_en[1]), .cfg_dout(cfg_dout[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  // Drives wq (gap before word i in gq[i]) into instance d.
  // Model: stream = words MSB-first, cut to chain length; a gap
  // g>0 costs g+1 dead cycles (g idle + the accept cycle).
  task automatic run_load(input int d, input int abort_at,
                          input string tag);
    int len;
    logic [63:0] exp_v, got_v;
    int nexp, ngot, widx, hold, cyc;
    int first_c, last_c, done_c, lows, exp_lows;
    bit fin, aborted;
    len = (d == 1) ? 20 : 48;
    exp_v = '0; got_v = '0;
    nexp = 0; ngot = 0; widx = 0; hold = 0; cyc = 0;
    first_c = -1; last_c = -1; done_c = -1;
    lows = 0; exp_lows = 0; fin = 0; aborted = 0;
    foreach (wq[i]) begin
      for (int b = 7; b >= 0; b--) begin
        if (nexp < len) begin
          exp_v = {exp_v[62:0], wq[i][b]};
          nexp++;
        end
      end
      if (i > 0 && i * 8 < len && gq[i] > 0)
        exp_lows += gq[i] + 1;
    end
    @(negedge clk); start[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0;
    chk({tag, "_start"}, {busy[d], done[d], err[d]}, 3'b100);
    while (!fin && cyc < 500) begin
      if (abort_at >= 0 && ngot == abort_at) begin
        abort[d] = 1'b1; in_valid[d] = 1'b0;
        @(negedge clk); abort[d] = 1'b0;
        chk({tag, "_abort"},
            {cfg_en[d], done[d], busy[d]}, 3'b000);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk({tag, "_abort_hold"},
              {cfg_en[d], done[d]}, 2'b00);
        end
        aborted = 1; fin = 1;
      end else begin
        if (cfg_en[d]) begin
          got_v = {got_v[62:0], cfg_dout[d]};
          ngot++;
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
        end else if (first_c >= 0 && !done[d]) begin
          lows++;
        end
        if (done[d]) begin
          done_c = cyc; fin = 1;
        end else begin
          if (hold > 0) begin
            if (!cfg_en[d]) hold--;
            in_valid[d] = 1'b0;
          end else if (widx < wq.size()) begin
            in_valid[d] = 1'b1;
            in_data[d] = wq[widx];
            if (in_ready[d]) begin
              widx++;
              hold = (widx < gq.size()) ? gq[widx] : 0;
            end
          end else begin
            in_valid[d] = 1'b0;
          end
          @(negedge clk);
          cyc++;
        end
      end
    end
    chk({tag, "_finished"}, 64'(fin), 64'd1);
    if (!aborted) begin
      chk({tag, "_status"},
          {busy[d], done[d], err[d]}, 3'b010);
      chk({tag, "_nbits"}, 64'(ngot), 64'(len));
      chk({tag, "_stream"}, got_v, exp_v);
      chk({tag, "_dead"}, 64'(lows), 64'(exp_lows));
      chk({tag, "_done_lat"}, 64'(done_c), 64'(last_c + 1));
      in_valid[d] = 1'b1; in_data[d] = 8'hFF;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk({tag, "_after"},
            {in_ready[d], cfg_en[d], done[d]}, 3'b001);
      end
      in_valid[d] = 1'b0;
    end
  endtask

  initial begin
    int n;
    nrst = 1'b1;
    start = '0; abort = '0; in_valid = '0;
    in_data[0] = '0; in_data[1] = '0;
    #1 nrst = 1'b0;
    #1;
    chk("reset_a", {in_ready[0], cfg_en[0], cfg_dout[0],
        busy[0], done[0], err[0]}, 6'b0);
    chk("reset_b", {in_ready[1], cfg_en[1], cfg_dout[1],
        busy[1], done[1], err[1]}, 6'b0);
    @(negedge clk); nrst = 1'b1;
    @(negedge clk);

    wq = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
    gq = '{0, 0, 0, 0, 0, 0};
    run_load(0, -1, "b2b48");

    wq = '{8'h12, 8'h34, 8'h56};
    gq = '{0, 0, 0};
    run_load(1, -1, "len20");

    wq = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
    gq = '{0, 3, 3, 3, 3, 3};
    run_load(0, -1, "gaps3");

    for (int r = 0; r < 3; r++) begin
      wq = {}; gq = {};
      for (int i = 0; i < 6; i++) begin
        wq.push_back(8'($urandom));
        gq.push_back(int'($urandom_range(0, 6)));
      end
      run_load(0, -1, "rand48");
      wq = {}; gq = {};
      for (int i = 0; i < 3; i++) begin
        wq.push_back(8'($urandom));
        gq.push_back(int'($urandom_range(0, 6)));
      end
      run_load(1, -1, "rand20");
    end

    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    n = 0;
    while (!err[0] && n < 40) begin
      @(negedge clk); n++;
    end
    chk("timeout_cycles", 64'(n), 64'd16);
    chk("timeout_state", {busy[0], err[0]}, 2'b01);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    chk("restart_clr", {busy[0], err[0]}, 2'b10);
    abort[0] = 1'b1;
    @(negedge clk); abort[0] = 1'b0;
    chk("abort_idle", {busy[0], cfg_en[0]}, 2'b00);

    wq = {}; gq = {};
    for (int i = 0; i < 6; i++) begin
      wq.push_back(8'($urandom));
      gq.push_back(0);
    end
    run_load(0, 13, "abort13");

    @(negedge clk);
    start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; abort[0] = 1'b0;
    chk("start_abort", {busy[0], cfg_en[0]}, 2'b00);

    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    in_valid[0] = 1'b1; in_data[0] = 8'hFF;
    repeat (4) @(negedge clk);
    chk("pre_reset_shift", {cfg_en[0], cfg_dout[0]}, 2'b11);
    #2 nrst = 1'b0;
    #1;
    chk("reset_mid", {in_ready[0], cfg_en[0], cfg_dout[0],
        busy[0], done[0], err[0]}, 6'b0);
    @(negedge clk); nrst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset", {in_ready[0], cfg_en[0], cfg_dout[0],
          busy[0], done[0], err[0]}, 6'b0);
    end
    in_valid[0] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
